// File: rtl/router_ingress_ctrl.sv
// Ingress controller of the 1x3 router: decodes packet headers, writes bytes into the
// selected output FIFO with full-flag retry, and checks the trailing parity byte.
module router_ingress_ctrl #(
    parameter logic [1:0] ADDR_INVALID = 2'b11
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    output logic       busy,
    output logic [7:0] dout,
    output logic [2:0] wr_en,
    output logic       lfd_state,
    output logic       parity_done,
    output logic       err
);

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_FIFO = 3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        CHECK_PARITY,
        DROP_PACKET
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_W-1:0]     r_header;
    logic [1:0]            r_tgt;
    logic [DATA_W-1:0]     r_calc;
    logic [DATA_W-1:0]     r_recv;
    logic [DATA_W-1:0]     r_dout;
    logic [NUM_FIFO-1:0]   r_wr_en;
    logic                  r_lfd;
    logic                  r_pdone;
    logic                  r_err;

    // Flags padded to four entries so every 2-bit address indexes in range
    logic [NUM_FIFO:0]     w_full4;
    logic [NUM_FIFO:0]     w_empty4;
    logic [NUM_FIFO:0]     w_srst4;
    logic [NUM_FIFO:0]     w_wr4;
    logic [NUM_FIFO-1:0]   w_onehot;
    logic                  w_stall;
    logic                  w_srst;
    logic                  w_busy;
    logic                  w_latch_hdr;
    logic                  w_load_hdr;
    logic                  w_load_byte;
    logic                  w_payload;
    logic                  w_parity;
    logic                  w_clr_wr;
    logic                  w_pdone;

    assign w_full4  = {1'b0, fifo_full};
    assign w_empty4 = {1'b0, fifo_empty};
    assign w_srst4  = {1'b0, soft_reset};
    assign w_wr4    = {1'b0, r_wr_en};
    assign w_stall  = w_wr4[r_tgt] & w_full4[r_tgt];
    assign w_srst   = w_srst4[r_tgt];

    always_comb begin
        w_onehot = '0;
        case (r_tgt)
            2'd0:    w_onehot = 3'b001;
            2'd1:    w_onehot = 3'b010;
            2'd2:    w_onehot = 3'b100;
            default: w_onehot = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, source back-pressure and per-edge datapath strobes
    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b0;
        w_latch_hdr = 1'b0;
        w_load_hdr  = 1'b0;
        w_load_byte = 1'b0;
        w_payload   = 1'b0;
        w_parity    = 1'b0;
        w_clr_wr    = 1'b0;
        w_pdone     = 1'b0;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (data_in[1:0] == ADDR_INVALID) begin
                        w_next = DROP_PACKET;
                    end else begin
                        w_latch_hdr = 1'b1;
                        w_next      = w_empty4[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                w_busy = 1'b1;
                if (w_srst) begin
                    w_clr_wr = 1'b1;
                    w_next   = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
                end else if (w_empty4[r_tgt]) begin
                    w_next = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                w_busy = 1'b1;
                if (w_srst) begin
                    w_clr_wr = 1'b1;
                    w_next   = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
                end else begin
                    w_load_hdr = 1'b1;
                    w_next     = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                w_busy = w_stall;
                if (w_srst) begin
                    w_clr_wr = 1'b1;
                    w_next   = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
                end else if (!w_stall) begin
                    w_load_byte = 1'b1;
                    if (pkt_valid) begin
                        w_payload = 1'b1;
                    end else begin
                        w_parity = 1'b1;
                        w_next   = CHECK_PARITY;
                    end
                end
            end
            CHECK_PARITY: begin
                w_busy = 1'b1;
                if (w_srst) begin
                    w_clr_wr = 1'b1;
                    w_next   = DECODE_ADDRESS;
                end else if (!w_stall) begin
                    w_pdone = 1'b1;
                    w_next  = DECODE_ADDRESS;
                end
            end
            DROP_PACKET: begin
                if (!pkt_valid) begin
                    w_next = DECODE_ADDRESS;
                end
            end
            default: begin
                w_next = DECODE_ADDRESS;
            end
        endcase
    end

    // Header, target and running / received parity
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_header <= '0;
            r_tgt    <= '0;
            r_calc   <= '0;
            r_recv   <= '0;
        end else begin
            if (w_latch_hdr) begin
                r_header <= data_in;
                r_tgt    <= data_in[1:0];
                r_calc   <= data_in;
            end else if (w_payload) begin
                r_calc <= r_calc ^ data_in;
            end
            if (w_parity) begin
                r_recv <= data_in;
            end
        end
    end

    // FIFO write port: a stalled write holds dout/wr_en until the FIFO takes it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dout  <= '0;
            r_wr_en <= '0;
            r_lfd   <= 1'b0;
            r_pdone <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_lfd   <= (w_next == LOAD_FIRST_DATA);
            r_pdone <= w_pdone;
            if (w_pdone) begin
                r_err <= (r_calc != r_recv);
            end else if (r_state == LOAD_FIRST_DATA) begin
                r_err <= 1'b0;
            end
            if (w_clr_wr) begin
                r_wr_en <= '0;
            end else if (w_load_hdr) begin
                r_dout  <= r_header;
                r_wr_en <= w_onehot;
            end else if (w_load_byte) begin
                r_dout  <= data_in;
                r_wr_en <= w_onehot;
            end else if (!w_stall) begin
                r_wr_en <= '0;
            end
        end
    end

    assign busy        = w_busy;
    assign dout        = r_dout;
    assign wr_en       = r_wr_en;
    assign lfd_state   = r_lfd;
    assign parity_done = r_pdone;
    assign err         = r_err;

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Bench for router_ingress_ctrl: directed timing cases plus random packet streams
// scored per FIFO against the bytes each packet should deliver.
module tb_router_ingress_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       busy;
    logic [7:0] dout;
    logic [2:0] wr_en;
    logic       lfd_state;
    logic       parity_done;
    logic       err;

    always #5 clk = ~clk;

    router_ingress_ctrl #(.ADDR_INVALID(2'b11)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .soft_reset  (soft_reset),
        .busy        (busy),
        .dout        (dout),
        .wr_en       (wr_en),
        .lfd_state   (lfd_state),
        .parity_done (parity_done),
        .err         (err)
    );

    logic [8:0] src_q[$];
    logic [7:0] exp_q[3][$];
    logic       exp_err[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         acc_cnt  = 0;
    logic [2:0] full_val  = 3'b000;
    logic [2:0] empty_val = 3'b111;
    logic [2:0] srst_val  = 3'b000;
    logic       last_busy = 1'b0;
    logic       prev_lfd  = 1'b0;
    logic [7:0] pay [8];
    logic [2:0] e_wr   [8];
    logic       e_lfd  [8];
    logic       e_busy [8];
    logic       e_pd   [8];
    logic [7:0] e_dout [8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue a packet at the source; valid addresses also queue what the FIFO must receive
    task automatic push_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par);
        logic [7:0] x;
        x = hdr;
        src_q.push_back({1'b1, hdr});
        for (int i = 0; i < n; i++) begin
            src_q.push_back({1'b1, pay[i]});
            x = x ^ pay[i];
        end
        src_q.push_back({1'b0, par});
        if (hdr[1:0] != 2'b11) begin
            exp_q[hdr[1:0]].push_back(hdr);
            for (int i = 0; i < n; i++) exp_q[hdr[1:0]].push_back(pay[i]);
            exp_q[hdr[1:0]].push_back(par);
            exp_err.push_back(x != par);
        end
    endtask

    // Score the write that lands at the coming edge and any parity result on view
    task automatic score();
        check_eq("wr_onehot", 32'($countones(wr_en) <= 1), 32'd1);
        if (prev_lfd) check_eq("lfd_then_write", 32'(wr_en != 3'b000), 32'd1);
        prev_lfd = lfd_state;
        for (int i = 0; i < 3; i++) begin
            if (wr_en[i] && !fifo_full[i]) begin
                check_eq($sformatf("fifo%0d_write_expected", i), 32'(exp_q[i].size() > 0), 32'd1);
                if (exp_q[i].size() > 0) check_eq($sformatf("fifo%0d_byte", i), 32'(dout), 32'(exp_q[i].pop_front()));
            end
        end
        if (parity_done) begin
            check_eq("parity_done_expected", 32'(exp_err.size() > 0), 32'd1);
            if (exp_err.size() > 0) check_eq("err", 32'(err), 32'(exp_err.pop_front()));
        end
    endtask

    task automatic tick();
        logic b;
        @(negedge clk);
        fifo_full  = full_val;
        fifo_empty = empty_val;
        soft_reset = srst_val;
        if (src_q.size() > 0) begin
            {pkt_valid, data_in} = src_q[0];
        end else begin
            pkt_valid = 1'b0;
            data_in   = 8'($urandom);
        end
        #1;
        score();
        b = busy;
        last_busy = b;
        @(posedge clk);
        if (!b && src_q.size() > 0) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (src_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", 32'(src_q.size()), 32'd0);
        repeat (10) tick();
    endtask

    initial begin
        resetn     = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        soft_reset = 3'b000;
        #1;
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_lfd", 32'(lfd_state), 32'd0);
        check_eq("rst_pdone", 32'(parity_done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Good packet to FIFO 1: cycle-exact view after each edge
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        push_pkt(8'h0D, 3, 8'h0D);
        e_wr   = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        e_lfd  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e_busy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        e_pd   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e_dout = '{8'h00, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00};
        for (int k = 0; k < 8; k++) begin
            tick();
            #2;
            check_eq($sformatf("t1_wr_en_c%0d", k), 32'(wr_en), 32'(e_wr[k]));
            check_eq($sformatf("t1_lfd_c%0d", k), 32'(lfd_state), 32'(e_lfd[k]));
            check_eq($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(e_busy[k]));
            check_eq($sformatf("t1_pdone_c%0d", k), 32'(parity_done), 32'(e_pd[k]));
            if (e_wr[k] != 3'b000) check_eq($sformatf("t1_dout_c%0d", k), 32'(dout), 32'(e_dout[k]));
        end
        check_eq("t1_err", 32'(err), 32'd0);

        // Same packet with a wrong parity byte
        push_pkt(8'h0D, 3, 8'h00);
        repeat (7) tick();
        #2;
        check_eq("t2_pdone", 32'(parity_done), 32'd1);
        check_eq("t2_err", 32'(err), 32'd1);

        // Target FIFO 0 not empty for 6 cycles
        pay[0] = 8'hC1;
        empty_val = 3'b110;
        push_pkt(8'h04, 1, 8'hC5);
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            #2;
            check_eq($sformatf("t3_busy_c%0d", k), 32'(busy), 32'd1);
            check_eq($sformatf("t3_wr_en_c%0d", k), 32'(wr_en), 32'd0);
        end
        empty_val = 3'b111;
        tick();
        #2;
        check_eq("t3_lfd", 32'(lfd_state), 32'd1);
        check_eq("t3_err_held", 32'(err), 32'd1);
        tick();
        #2;
        check_eq("t3_hdr_wr_en", 32'(wr_en), 32'(3'b001));
        check_eq("t3_hdr_dout", 32'(dout), 32'h04);
        check_eq("t3_err_cleared", 32'(err), 32'd0);
        drain(200);

        // FIFO 2 full for 3 cycles while the third payload byte is on the port
        for (int i = 0; i < 6; i++) pay[i] = 8'hA1 + 8'(i);
        push_pkt(8'h1A, 6, 8'h1A ^ 8'hA1 ^ 8'hA2 ^ 8'hA3 ^ 8'hA4 ^ 8'hA5 ^ 8'hA6);
        repeat (5) tick();
        full_val = 3'b100;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("t4_busy_c%0d", k), 32'(last_busy), 32'd1);
            #2;
            check_eq($sformatf("t4_dout_c%0d", k), 32'(dout), 32'hA3);
            check_eq($sformatf("t4_wr_en_c%0d", k), 32'(wr_en), 32'(3'b100));
        end
        full_val = 3'b000;
        drain(200);

        // Invalid address packet dropped, then a zero-length packet to FIFO 1
        pay[0] = 8'h55;
        push_pkt(8'h07, 1, 8'h52);
        push_pkt(8'h01, 0, 8'h01);
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            check_eq($sformatf("t5_wr_en_c%0d", k), 32'(wr_en), 32'd0);
        end
        drain(200);

        // Soft reset of FIFO 1 after two payload bytes were accepted
        src_q.push_back({1'b1, 8'h11});
        src_q.push_back({1'b1, 8'h31});
        src_q.push_back({1'b1, 8'h32});
        src_q.push_back({1'b1, 8'h33});
        src_q.push_back({1'b1, 8'h34});
        src_q.push_back({1'b0, 8'h00});
        exp_q[1].push_back(8'h11);
        exp_q[1].push_back(8'h31);
        exp_q[1].push_back(8'h32);
        pay[0] = 8'h77;
        push_pkt(8'h05, 1, 8'h72);
        acc_cnt = 0;
        for (int n = 0; n < 20 && acc_cnt < 3; n++) tick();
        check_eq("t6_accepted", 32'(acc_cnt), 32'd3);
        srst_val = 3'b010;
        tick();
        srst_val = 3'b101;
        #2;
        check_eq("t6_wr_en_cleared", 32'(wr_en), 32'd0);
        check_eq("t6_busy_drop", 32'(busy), 32'd0);
        drain(200);
        srst_val = 3'b000;

        // Asynchronous reset in the middle of a packet
        pay[0] = 8'hE1; pay[1] = 8'hE2; pay[2] = 8'hE3;
        push_pkt(8'h0C, 3, 8'h0C ^ 8'hE1 ^ 8'hE2 ^ 8'hE3);
        repeat (4) tick();
        #2;
        pkt_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        check_eq("t7_dout", 32'(dout), 32'd0);
        check_eq("t7_wr_en", 32'(wr_en), 32'd0);
        check_eq("t7_lfd", 32'(lfd_state), 32'd0);
        check_eq("t7_pdone", 32'(parity_done), 32'd0);
        check_eq("t7_err", 32'(err), 32'd0);
        check_eq("t7_busy", 32'(busy), 32'd0);
        src_q.delete();
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        exp_err.delete();
        prev_lfd = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Random packet stream with random full/empty flags
        for (int p = 0; p < 40; p++) begin
            int n;
            logic [7:0] hdr;
            logic [7:0] par;
            n   = int'($urandom_range(0, 5));
            hdr = {6'($urandom), 2'($urandom_range(0, 3))};
            par = hdr;
            for (int i = 0; i < n; i++) begin
                pay[i] = 8'($urandom);
                par    = par ^ pay[i];
            end
            if ($urandom_range(0, 1) == 1) par = par ^ 8'($urandom_range(1, 255));
            push_pkt(hdr, n, par);
        end
        begin
            int n;
            n = 0;
            while (src_q.size() > 0 && n < 20000) begin
                for (int i = 0; i < 3; i++) begin
                    full_val[i]  = ($urandom_range(0, 3) == 0);
                    empty_val[i] = ($urandom_range(0, 3) != 0);
                end
                tick();
                n++;
            end
        end
        check_eq("rand_timeout", 32'(src_q.size()), 32'd0);
        full_val  = 3'b000;
        empty_val = 3'b111;
        repeat (20) tick();

        for (int i = 0; i < 3; i++) check_eq($sformatf("fifo%0d_leftover", i), 32'(exp_q[i].size()), 32'd0);
        check_eq("parity_leftover", 32'(exp_err.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/router_ingress_ctrl.md
# router_ingress_ctrl

Input-side controller of the 1x3 router. It accepts the serial byte stream from the source, decodes the destination from each header, and stalls the source with `busy`. It drives the write side of the three output FIFOs: `dout`, one-hot `wr_en` and `lfd_state`, timed for the FIFO's one-cycle internal `lfd_state` register. It also computes running parity and flags a mismatch against the packet's trailing parity byte.

## Interface
- `ADDR_INVALID`, default 2'b11: header address code that is dropped.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: high during header and payload bytes; low during the parity byte.
- `data_in` in 8: source byte. Header is [7:2] payload length, [1:0] address.
- `fifo_full` in 3: full flags of FIFOs 0..2.
- `fifo_empty` in 3: empty flags of FIFOs 0..2.
- `soft_reset` in 3: per-FIFO timeout flush; aborts a packet targeting that FIFO.
- `busy` out 1: source must hold `data_in`/`pkt_valid` while high.
- `dout` out 8: registered byte to FIFOs.
- `wr_en` out 3: registered one-hot write enable, aligned with `dout`.
- `lfd_state` out 1: high exactly one cycle before the header write.
- `parity_done` out 1: one-cycle pulse when a packet's parity check completes.
- `err` out 1: parity mismatch on the last completed packet.

## Operation
- Reset values: state DECODE_ADDRESS; `dout`=0, `wr_en`=0, `lfd_state`=0, `parity_done`=0, `err`=0, `busy`=0; internal header, target, calc/received parity all 0.
- `stall` = `wr_en`[tgt] && `fifo_full`[tgt]. A write issued into a full FIFO is lost, so while `stall` is high, `dout` and `wr_en` hold their values (retry).
- Byte accept: a byte is taken at a clock edge in an accepting state when `busy`=0.
- Packet bytes (header, payload, parity) load `dout`/`wr_en` at the accept edge.
- If no byte loads and `stall`=0, `wr_en` returns to 0 on the next edge.
- DECODE_ADDRESS: `busy`=0.
  - `pkt_valid` && addr==`ADDR_INVALID`: go to DROP_PACKET.
  - Otherwise, on `pkt_valid`: latch header and tgt=addr, set calc parity=header.
    - `fifo_empty`[tgt] high: go to LOAD_FIRST_DATA.
    - `fifo_empty`[tgt] low: go to WAIT_TILL_EMPTY.
- WAIT_TILL_EMPTY: `busy`=1. Go to LOAD_FIRST_DATA when `fifo_empty`[tgt] is high.
- LOAD_FIRST_DATA: `busy`=1, `lfd_state`=1, lasts one cycle. `err` clears. Edge loads `dout`=header, `wr_en`=onehot(tgt). Go to LOAD_DATA.
- LOAD_DATA: `busy`=`stall`. On accept:
  - `pkt_valid`=1: payload byte written, calc ^= byte.
  - `pkt_valid`=0: byte is parity; written and latched as received parity. Go to CHECK_PARITY.
- CHECK_PARITY: `busy`=1. On the first edge with `stall`=0 (parity write landed): `err` <= (calc != received), `parity_done` pulses one cycle, go to DECODE_ADDRESS.
- DROP_PACKET: `busy`=0, no writes. Consumes bytes while `pkt_valid`=1; the byte with `pkt_valid`=0 is consumed, then go to DECODE_ADDRESS.
- `soft_reset`[tgt] in WAIT_TILL_EMPTY, LOAD_FIRST_DATA or LOAD_DATA: `wr_en`<=0, go to DROP_PACKET. Exception: if the byte on `data_in` has `pkt_valid`=0, consume it and go to DECODE_ADDRESS instead.
- `soft_reset`[tgt] in CHECK_PARITY: `wr_en`<=0, no `parity_done`, go to DECODE_ADDRESS.
- `soft_reset` of a non-target FIFO is ignored.
- Length field is not checked against the byte count; packet end is defined by `pkt_valid` only. Length 0 means header then parity.
- Parity is the 8-bit XOR of header and all payload bytes.

## Timing
- Header on `data_in` at T0 (DECODE, target empty): `lfd_state`=1 and `busy`=1 at T1; `dout`=header with `wr_en`=onehot at T2.
- First payload byte is presented at T1, held through T1 by `busy`, and accepted at the end of T2.
- Every accepted byte appears on `dout`/`wr_en` the cycle after acceptance; writes are back-to-back at one byte per cycle without stall.
- Parity byte accepted at Tp: parity write at Tp+1; `parity_done`/`err` update at Tp+2 with no stall. Earliest next header accept is also Tp+2.
- `busy` is combinational from state and `stall`; all other outputs are registered.
- `resetn` low at any time: immediate return to reset values; a partial packet is abandoned. The source must restart at a header.

## Test plan
- Header 0x0D, payload 0x11, 0x22, 0x33, parity 0x0D, all FIFOs empty -> `lfd_state` for one cycle, then `wr_en`=3'b010 for 5 consecutive cycles with `dout` 0D, 11, 22, 33, 0D; `parity_done` pulse; `err`=0.
- Same packet with parity byte 0x00 -> all 5 bytes written; `err`=1 after `parity_done`. `err` clears at the next LOAD_FIRST_DATA.
- Header 0x04 (addr 0) with `fifo_empty`[0]=0 for 6 cycles -> `busy`=1 and no `wr_en` until empty rises; then normal sequence with no byte lost.
- Addr 2 packet, 6-byte payload, `fifo_full`[2] high for 3 cycles during the 3rd payload write -> `dout`/`wr_en` held, `busy`=1 for 3 cycles; FIFO receives each byte exactly once, in order.
- Header 0x07 (addr 3), 1 payload byte, parity, then valid packet to addr 1 -> no `wr_en` for the first packet; second packet written correctly.
- `soft_reset`[1] during the payload of an addr-1 packet -> `wr_en`=0 next cycle, remaining bytes dropped, next packet accepted. Separately, `resetn` low mid-packet -> all outputs 0 asynchronously.
